// File: rtl/gsim_x_packer.sv
// gsim_x_packer: packs solver x-result writes into 8-word lines queued in a 2-entry line FIFO.
// Define XPACK_CHECKSUM_EN to add o_line_sum, the word sum of the head line.
module gsim_x_packer (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_x_wen,
    input  logic [8:0]   i_x_addr,
    input  logic [31:0]  i_x_data,
    input  logic         i_flush,
    output logic         o_line_vld,
    input  logic         i_line_rdy,
    output logic [5:0]   o_line_addr,
    output logic [255:0] o_line_data,
    output logic [7:0]   o_line_mask,
`ifdef XPACK_CHECKSUM_EN
    output logic [31:0]  o_line_sum,
`endif
    output logic         o_overflow,
    output logic         o_busy
);
    localparam int LINE_WORDS = 8;
    localparam int FIFO_DEPTH = 2;
    localparam logic [1:0] EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2;
    logic [5:0]   asm_base, nxt_base, push_addr, w_base;
    logic [255:0] asm_data, nxt_data, push_data, merged, single;
    logic [7:0]   asm_mask, nxt_mask, push_mask, w_bit;
    logic [2:0]   idx;
    logic         hit, push, pop, accept, drop;
    logic [1:0]   occ, nxt_occ;
    logic         rd_ptr, wr_ptr;
    logic [5:0]   f_addr [FIFO_DEPTH];
    logic [255:0] f_data [FIFO_DEPTH];
    logic [7:0]   f_mask [FIFO_DEPTH];
    assign idx    = i_x_addr[2:0];
    assign w_base = i_x_addr[8:3];
    assign w_bit  = 8'b1 << idx;
    assign hit    = asm_mask == '0 || asm_base == w_base;
    always_comb begin
        merged = asm_data;
        merged[32*idx +: 32] = i_x_data;
        single = '0;
        single[32*idx +: 32] = i_x_data;
    end
    // A write always wins over flush; a base change pushes the old line and restarts with the new word.
    always_comb begin
        push      = i_x_wen ? (!hit || idx == 3'd7) : (i_flush && asm_mask != '0);
        push_addr = (i_x_wen && hit) ? w_base : asm_base;
        push_data = (i_x_wen && hit) ? merged : asm_data;
        push_mask = (i_x_wen && hit) ? (asm_mask | w_bit) : asm_mask;
        nxt_base  = i_x_wen ? w_base : asm_base;
        nxt_data  = i_x_wen ? (!hit ? single : (idx == 3'd7 ? '0 : merged)) : (push ? '0 : asm_data);
        nxt_mask  = i_x_wen ? (!hit ? w_bit : (idx == 3'd7 ? '0 : asm_mask | w_bit)) : (push ? '0 : asm_mask);
    end
    assign o_line_vld = occ != EMPTY;
    assign pop        = o_line_vld && i_line_rdy;
    assign accept     = push && (occ != FULL || pop);
    assign drop       = push && occ == FULL && !pop;
    assign nxt_occ    = occ + 2'(accept) - 2'(pop);
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            asm_base   <= '0;
            asm_data   <= '0;
            asm_mask   <= '0;
            occ        <= EMPTY;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            o_overflow <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            asm_base   <= nxt_base;
            asm_data   <= nxt_data;
            asm_mask   <= nxt_mask;
            occ        <= nxt_occ;
            rd_ptr     <= rd_ptr ^ pop;
            wr_ptr     <= wr_ptr ^ accept;
            o_overflow <= o_overflow | drop;
            o_busy     <= nxt_mask != '0 || nxt_occ != EMPTY;
        end
    end
    // Entries need no reset: outputs are forced to zero while the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            f_addr[wr_ptr] <= push_addr;
            f_data[wr_ptr] <= push_data;
            f_mask[wr_ptr] <= push_mask;
        end
    end
    assign o_line_addr = o_line_vld ? f_addr[rd_ptr] : '0;
    assign o_line_data = o_line_vld ? f_data[rd_ptr] : '0;
    assign o_line_mask = o_line_vld ? f_mask[rd_ptr] : '0;
`ifdef XPACK_CHECKSUM_EN
    logic [31:0] push_sum;
    logic [31:0] f_sum [FIFO_DEPTH];
    always_comb begin
        push_sum = '0;
        for (int k = 0; k < LINE_WORDS; k++) push_sum += push_mask[k] ? push_data[32*k +: 32] : 32'd0;
    end
    always_ff @(posedge i_clk) begin
        if (accept) f_sum[wr_ptr] <= push_sum;
    end
    assign o_line_sum = o_line_vld ? f_sum[rd_ptr] : '0;
`endif
endmodule

// File: doc/gsim_x_packer.md
# gsim_x_packer

Downstream stage of the Gauss-Seidel solver (`GSIM`). It consumes the solver's 32-bit x-result write stream (`wen/addr/data`, one word at a time, no backpressure) and packs words into 256-bit, 8-word lines. Lines are delivered to the output memory over a valid/ready port through a 2-entry line FIFO. It absorbs output-side stalls without ever stalling the solver, and it reports drops caused by FIFO overflow.

## Interface
- `LINE_WORDS`, 8: words per line; fixed at 8 because the line is 256 bits of 32-bit words.
- `FIFO_DEPTH`, 2: line FIFO entries.
- `i_clk`  in  1  clock; all logic is on the rising edge.
- `i_reset`  in  1  reset; synchronous, active-high.
- `i_x_wen`  in  1  x write strobe from the solver.
- `i_x_addr`  in  9  word address. `[8:3]` is the line base; `[2:0]` is the word index.
- `i_x_data`  in  32  signed x value.
- `i_flush`  in  1  level request to emit the pending partial line; tied to solver `o_proc_done`.
- `o_line_vld`  out  1  FIFO head valid.
- `i_line_rdy`  in  1  sink ready. Transfer happens when `vld & rdy` at a clock edge.
- `o_line_addr`  out  6  line base of the head line.
- `o_line_data`  out  256  word k occupies bits `[32k+31:32k]`; unwritten words are 0.
- `o_line_mask`  out  8  bit k = word k valid.
- `o_overflow`  out  1  sticky; set when a line is dropped because the FIFO was full.
- `o_busy`  out  1  high while a partial line is pending or the FIFO is non-empty.

## Operation
- Assembly register (ASM) holds `base[5:0]`, `data[255:0]` and `mask[7:0]`. ASM is empty when `mask == 0`.
- At most one FIFO push and one FIFO pop per cycle.
- **Write, ASM empty or ASM base == `addr[8:3]`:**
  - Word `idx = addr[2:0]` is merged into ASM; a repeat write to the same idx overwrites the data.
  - If `idx == 7`, the merged line is pushed on this edge and ASM is cleared.
  - Otherwise the word stays in ASM.
- **Write, ASM non-empty and base differs:**
  - The old ASM is pushed unchanged.
  - ASM reloads with the new word only, even when `idx == 7`. That single-word line is emitted later, by a flush or the next base change.
- **`i_flush` high, no write this cycle, ASM non-empty:** ASM is pushed and cleared.
  - If a write is present in the same cycle, the write takes priority.
  - The flush is serviced on the first write-free cycle while `i_flush` is still high.
- **Push with FIFO full and no pop on the same edge:**
  - The line is discarded and `o_overflow` is set. It stays set until reset.
  - ASM is still updated or cleared exactly as if the push had succeeded.
- **Push with FIFO full and a pop on the same edge:** the push is accepted; no overflow.
- FIFO order is strict FIFO. While `o_line_vld` is high and `i_line_rdy` is low, `o_line_addr`, `o_line_data` and `o_line_mask` stay stable.
- No arithmetic is applied to data; words pass through bit-exact.

## Timing
- **Reset values:** `o_line_vld`=0, `o_line_addr`=0, `o_line_data`=0, `o_line_mask`=0, `o_overflow`=0, `o_busy`=0. ASM is cleared and the FIFO is emptied. Reset mid-operation discards all pending words and lines with no output.
- **Push latency:** a push on edge t makes `o_line_vld`=1 in cycle t+1 if the FIFO was empty.
- **Throughput:** a line can be pushed and popped back-to-back, one line per cycle.
- **`o_busy`** is registered and reflects ASM/FIFO state after each edge.
- **FIFO occupancy states:** EMPTY, ONE, FULL.

| From | Event | To |
|---|---|---|
| EMPTY | push | ONE |
| ONE | push only | FULL |
| ONE | pop only | EMPTY |
| ONE | push and pop | ONE |
| FULL | pop | ONE |
| FULL | push and pop | FULL |

## Configuration
- `XPACK_CHECKSUM_EN` defined:
  - Adds output `o_line_sum[31:0]`, the modulo-2^32 sum of the masked words of the head line.
  - The sum is computed at push time and stored in the FIFO alongside the line.
  - Its reset value is 0.
- Undefined: the port and its storage are absent; all other behaviour is identical.

## Test plan
1. **Full line, sink always ready.** Write addr 0..7 with data 1..8, one every 2 cycles, `i_line_rdy`=1 → exactly one line with addr 0, mask FF, word k = k+1, `o_line_vld` for 1 cycle, `o_busy`=0 afterwards.
2. **Base change.** Write addr 16..20, then addr 32 → line with addr 2, mask 1F is pushed. ASM holds addr 4, mask 01. Then raise `i_flush` → line with addr 4, mask 01 emitted.
3. **Overflow.** `i_line_rdy`=0, three complete lines written (addrs 0..23) → first two lines held stable, third dropped, `o_overflow`=1. Then `i_line_rdy`=1 → exactly lines 0 and 1 are delivered.
4. **Full FIFO with simultaneous pop.** FIFO full, and on the edge that completes a third line `i_line_rdy`=1 → no overflow, three lines delivered in order.
5. **Flush and write collision.** `i_flush`=1 while writing addr 8 into ASM holding base 0 → base-0 line pushed. Addr 8 stays in ASM and is pushed on the next write-free cycle (mask 01, addr 1).
6. **Reset mid-line.** Write 5 words, assert `i_reset` one cycle → all outputs 0 and no line is ever emitted for those words. With `XPACK_CHECKSUM_EN` defined, test 1 additionally checks `o_line_sum`=36.
